irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Parametrised interrupt controller between external event sources (frame_interrupt, UART, future peripherals) and the MIPS150 CP0 interrupt input. It synchronises up to 31 asynchronous sources and latches each one per source as edge- or level-sensitive. It masks and priority-encodes the sources into one registered request with a source ID, and exposes a small memory-mapped register window on the data-memory I/O path. It generalises the single hard-wired frame_interrupt line into N configurable channels with pending/clear/ack semantics and an optional compare timer.

## Interface
- NUM_SRC, 4, number of external sources (1..31)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  1  CPU stall; qualifies reg_we/reg_re/irq_ack (ignored when 1)
- irq_src  in  NUM_SRC  raw asynchronous source lines, active-high
- reg_addr  in  5  byte offset into register window, bits [4:2] decode
- reg_we  in  1  register write strobe
- reg_re  in  1  register read strobe
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, reset 0
- irq_out  out  1  registered request to CP0, reset 0
- irq_id  out  5  registered ID of highest-priority active source, reset 0
- irq_ack  in  1  one-cycle pulse from CP0 on ISR entry

## Operation
- Sync: per source s1<=src, s2<=s1, s3<=s2; edge = s2 & ~s3. All three flops reset to 0.
- Registers (offset, access, reset):
  - 0x00 STATUS: RO, pending bits.
  - 0x04 MASK: RW, 0.
  - 0x08 MODE: RW, all 1; 1=edge, 0=level.
  - 0x0C CLEAR: WO, write-1-to-clear, reads 0.
  - 0x10 TIMER_CNT: RW, 0.
  - 0x14 TIMER_CMP: RW, 0xFFFFFFFF.
  - 0x18/0x1C: read 0, writes ignored.
- Bits at or above NUM_SRC are read 0 and writes to them are ignored. Bit 31 is the exception: it is implemented when the timer is compiled in.
- Edge mode: pending sets on edge and holds until CLEAR or irq_ack. Set wins over a same-cycle clear.
- Level mode: pending = s2 every cycle. CLEAR and ack have no effect.
- MODE change: switching to level loads s2 next cycle. Switching to edge keeps the current pending value.
- active = pending & MASK.
  - irq_out <= |active.
  - irq_id <= index of lowest set bit of active (bit 0 highest priority, bit 31 lowest). When active is 0, irq_id holds its previous value.
- irq_ack clears the edge-mode pending bit selected by the current irq_id. The ack is ignored if stall=1 or irq_out=0.
- Reads: reg_rdata <= selected register when reg_re & ~stall. Otherwise it holds its value.

## Timing
- Source latency: irq_src high before edge k gives STATUS bit = 1 after edge k+2 and irq_out = 1 after edge k+3.
- Pulses shorter than one clock period may be missed. Minimum guaranteed width is 2 cycles.
- Register write takes effect after the write edge. Request update is 1 cycle later:
  - MASK write at edge k gives irq_out change after k+1.
  - CLEAR at edge k gives pending=0 after k and irq_out=0 after k+1.
- Read latency: 1 cycle.
- Simultaneous CLEAR and irq_ack are OR-ed.
- Reset asserted mid-operation clears all state immediately. A source held high across reset release appears as an edge 3 cycles after release.

## Configuration
- IRQ_TIMER_EN defined:
  - TIMER_CNT increments every cycle, including during stall.
  - When CNT == CMP, pending[31] sets (always edge-type, MODE[31] forced 1) and CNT loads 0 next cycle.
  - A CNT write takes precedence over increment and wrap.
  - CMP=0 sets pending every cycle.
- IRQ_TIMER_EN undefined: 0x10/0x14 read 0, bit 31 is absent, and no counter logic is generated.

## Test plan
- NUM_SRC=4, MASK=0xF, src[2] rises at edge 10: STATUS=0x4 after edge 12, irq_out=1 and irq_id=2 after edge 13. Write CLEAR=0x4: irq_out=0 one cycle later.
- src[1] and src[3] rise together, MASK=0xA: irq_id=1. irq_ack: irq_id=3, irq_out stays 1. Second ack: irq_out=0.
- MODE=0xE (src0 level), src[0] high 5 cycles: STATUS[0] tracks the level with 2-cycle delay. CLEAR=0x1 has no effect.
- New edge on src[2] in the same cycle as CLEAR=0x4: STATUS[2] remains 1.
- IRQ_TIMER_EN, CMP=9, MASK[31]=1: irq_out after CNT reaches 9 (edge 10 from reset release, irq_out after edge 11), irq_id=31, CNT=0 next cycle. Without the macro: reads of 0x10/0x14 return 0.
- Reset pulsed low mid-interrupt with src held high: all outputs 0 immediately. After release with MASK rewritten, pending reappears 3 cycles after release.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Register-window bus between the CPU data-memory I/O path (master) and irq_ctrl (slave).
interface irq_ctrl_if;
    logic [4:0]  reg_addr;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    modport master (output reg_addr, reg_we, reg_re, reg_wdata, input reg_rdata);
    modport slave  (input reg_addr, reg_we, reg_re, reg_wdata, output reg_rdata);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronises, latches, masks and priority-encodes NUM_SRC interrupt sources for CP0.
// Optional compare timer on bit 31 is compiled in by defining IRQ_TIMER_EN.
module irq_ctrl #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [NUM_SRC-1:0] irq_src,
    irq_ctrl_if.slave          regBus,
    output logic               irq_out,
    output logic [4:0]         irq_id,
    input  logic               irq_ack
);
    typedef enum logic [2:0] {
        REG_STATUS = 3'd0,
        REG_MASK   = 3'd1,
        REG_MODE   = 3'd2,
        REG_CLEAR  = 3'd3,
        REG_TCNT   = 3'd4,
        REG_TCMP   = 3'd5,
        REG_RSV6   = 3'd6,
        REG_RSV7   = 3'd7
    } regSel_e;

    localparam logic [31:0] SRC_BITS = 32'((64'd1 << NUM_SRC) - 64'd1);
`ifdef IRQ_TIMER_EN
    localparam logic [31:0] TIMER_BIT = 32'h8000_0000;
`else
    localparam logic [31:0] TIMER_BIT = 32'h0000_0000;
`endif
    localparam logic [31:0] IMPL_BITS = SRC_BITS | TIMER_BIT;

    logic [NUM_SRC-1:0] s1, s2, s3;
    logic [31:0]        pending, pendingNext, mask, mode, rdata, rdSel;
    logic [31:0]        edgeVec, levelVec, clrVec, active;
    logic [4:0]         lowId;
    logic               wrEn, rdEn, ackEn;
    regSel_e            sel;
    logic [1:0]         unusedAddr;

    assign sel        = regSel_e'(regBus.reg_addr[4:2]);
    assign unusedAddr = regBus.reg_addr[1:0];
    assign wrEn       = regBus.reg_we & ~stall;
    assign rdEn       = regBus.reg_re & ~stall;
    assign ackEn      = irq_ack & ~stall & irq_out;
    assign active     = pending & mask;

`ifdef IRQ_TIMER_EN
    logic [31:0] cnt, cmp;
    logic        timerHit;

    assign timerHit = (cnt == cmp);

    // Counter runs through stall; an explicit CNT write beats both increment and wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            cmp <= '1;
        end else begin
            if (wrEn && sel == REG_TCNT)
                cnt <= regBus.reg_wdata;
            else if (timerHit)
                cnt <= '0;
            else
                cnt <= cnt + 32'd1;
            if (wrEn && sel == REG_TCMP)
                cmp <= regBus.reg_wdata;
        end
    end
`endif

    // Edge bits: set wins over clear/ack. Level bits: follow s2 directly.
    always_comb begin
        edgeVec  = 32'(s2 & ~s3);
        levelVec = 32'(s2);
`ifdef IRQ_TIMER_EN
        edgeVec[31] = timerHit;
`endif
        clrVec = '0;
        if (wrEn && sel == REG_CLEAR)
            clrVec = regBus.reg_wdata;
        if (ackEn)
            clrVec[irq_id] = 1'b1;
        pendingNext = ((mode & (edgeVec | (pending & ~clrVec))) | (~mode & levelVec)) & IMPL_BITS;
    end

    always_comb begin
        lowId = '0;
        for (int unsigned i = 32; i > 0; i--) begin
            if (active[5'(i - 1)])
                lowId = 5'(i - 1);
        end
    end

    always_comb begin
        rdSel = '0;
        case (sel)
            REG_STATUS: rdSel = pending;
            REG_MASK:   rdSel = mask;
            REG_MODE:   rdSel = mode;
`ifdef IRQ_TIMER_EN
            REG_TCNT:   rdSel = cnt;
            REG_TCMP:   rdSel = cmp;
`endif
            default:    rdSel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            pending <= '0;
            mask    <= '0;
            mode    <= IMPL_BITS;
            rdata   <= '0;
            irq_out <= 1'b0;
            irq_id  <= '0;
        end else begin
            s1      <= irq_src;
            s2      <= s1;
            s3      <= s2;
            pending <= pendingNext;
            if (wrEn && sel == REG_MASK)
                mask <= regBus.reg_wdata & IMPL_BITS;
            if (wrEn && sel == REG_MODE)
                mode <= (regBus.reg_wdata & IMPL_BITS) | TIMER_BIT;
            if (rdEn)
                rdata <= rdSel;
            irq_out <= |active;
            if (|active)
                irq_id <= lowId;
        end
    end

    assign regBus.reg_rdata = rdata;
endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_irq_ctrl;
    localparam int NUM_SRC = 4;
`ifdef IRQ_TIMER_EN
    localparam logic [31:0] IMPL = 32'h8000_000F;
`else
    localparam logic [31:0] IMPL = 32'h0000_000F;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               stall;
    logic               irq_ack;
    logic [NUM_SRC-1:0] irq_src;
    logic               irq_out;
    logic [4:0]         irq_id;

    irq_ctrl_if bus ();

    irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .irq_src (irq_src),
        .regBus  (bus.slave),
        .irq_out (irq_out),
        .irq_id  (irq_id),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state
    logic [31:0]        mPend, mMask, mMode, mRd, mCnt, mCmp;
    logic               mOut;
    logic [4:0]         mId;
    logic [NUM_SRC-1:0] srcHist[$];   // [0] newest sample, [2] oldest

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPend = '0;
        mMask = '0;
        mMode = IMPL;
        mRd   = '0;
        mCnt  = '0;
        mCmp  = '1;
        mOut  = 1'b0;
        mId   = '0;
        srcHist = {};
        repeat (3) srcHist.push_back('0);
    endtask

    task automatic modelEdge();
        logic [31:0] lvl, edg, clr, act, nP, nCnt;
        logic [4:0]  off;
        bit          wE, rE;
        lvl = 32'(srcHist[1]);
        edg = 32'(srcHist[1] & ~srcHist[2]);
        wE  = bus.reg_we && !stall;
        rE  = bus.reg_re && !stall;
        off = bus.reg_addr & 5'h1C;
        clr = '0;
        if (wE && off == 5'h0C) clr = bus.reg_wdata;
        if (irq_ack && !stall && mOut) clr[mId] = 1'b1;
`ifdef IRQ_TIMER_EN
        if (mCnt == mCmp) edg[31] = 1'b1;
`endif
        for (int b = 0; b < 32; b++) begin
            if (!IMPL[b])      nP[b] = 1'b0;
            else if (mMode[b]) nP[b] = edg[b] | (mPend[b] & ~clr[b]);
            else               nP[b] = lvl[b];
        end
        act = mPend & mMask;
        if (act != 0) begin
            mOut = 1'b1;
            for (int b = 31; b >= 0; b--)
                if (act[b]) mId = 5'(b);
        end else begin
            mOut = 1'b0;
        end
        if (rE) begin
            case (off)
                5'h00:   mRd = mPend;
                5'h04:   mRd = mMask;
                5'h08:   mRd = mMode;
`ifdef IRQ_TIMER_EN
                5'h10:   mRd = mCnt;
                5'h14:   mRd = mCmp;
`endif
                default: mRd = '0;
            endcase
        end
        nCnt = mCnt + 1;
        if (mCnt == mCmp) nCnt = '0;
        if (wE && off == 5'h10) nCnt = bus.reg_wdata;
`ifdef IRQ_TIMER_EN
        mCnt = nCnt;
        if (wE && off == 5'h14) mCmp = bus.reg_wdata;
`endif
        if (wE && off == 5'h04) mMask = bus.reg_wdata & IMPL;
        if (wE && off == 5'h08) mMode = (bus.reg_wdata & IMPL) | (IMPL & 32'h8000_0000);
        mPend = nP;
        srcHist.push_front(irq_src);
        void'(srcHist.pop_back());
    endtask

    // One clock: model advances on the rising edge, DUT outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) modelEdge();
        @(negedge clk);
        checkEq("irq_out", 32'(irq_out), 32'(mOut));
        checkEq("irq_id", 32'(irq_id), 32'(mId));
        checkEq("reg_rdata", bus.reg_rdata, mRd);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        bus.reg_we = 1'b1; bus.reg_addr = addr; bus.reg_wdata = data;
        cycle();
        bus.reg_we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] addr);
        bus.reg_re = 1'b1; bus.reg_addr = addr;
        cycle();
        bus.reg_re = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; irq_ack = 1'b0; irq_src = '0;
        bus.reg_we = 1'b0; bus.reg_re = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
        modelReset();
        #1 rst = 1'b0;
        repeat (3) cycle();
        checkEq("rst_irq_out", 32'(irq_out), 32'h0);
        checkEq("rst_rdata", bus.reg_rdata, 32'h0);
        rst = 1'b1;
        rd(5'h08);
        checkEq("rst_mode", bus.reg_rdata, IMPL);

        // Edge source latency and CLEAR
        wr(5'h04, 32'hF);
        irq_src[2] = 1'b1;
        repeat (3) cycle();
        checkEq("t1_out_early", 32'(irq_out), 32'h0);
        rd(5'h00);
        checkEq("t1_status", bus.reg_rdata, 32'h4);
        checkEq("t1_out", 32'(irq_out), 32'h1);
        checkEq("t1_id", 32'(irq_id), 32'd2);
        wr(5'h0C, 32'h4);
        checkEq("t1_out_hold", 32'(irq_out), 32'h1);
        cycle();
        checkEq("t1_out_clr", 32'(irq_out), 32'h0);

        // Priority and ack
        wr(5'h04, 32'hA);
        irq_src[1] = 1'b1; irq_src[3] = 1'b1;
        repeat (4) cycle();
        checkEq("t2_id1", 32'(irq_id), 32'd1);
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        cycle();
        checkEq("t2_id3", 32'(irq_id), 32'd3);
        checkEq("t2_out_still", 32'(irq_out), 32'h1);
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        cycle();
        checkEq("t2_out_done", 32'(irq_out), 32'h0);

        // Level mode on source 0; CLEAR has no effect
        wr(5'h08, 32'hE);
        wr(5'h04, 32'h1);
        irq_src[0] = 1'b1;
        repeat (4) rd(5'h00);
        checkEq("t3_level_hi", bus.reg_rdata & 32'h1, 32'h1);
        wr(5'h0C, 32'h1);
        rd(5'h00);
        checkEq("t3_clr_noeff", bus.reg_rdata & 32'h1, 32'h1);
        irq_src[0] = 1'b0;
        repeat (4) rd(5'h00);
        checkEq("t3_level_lo", bus.reg_rdata & 32'h1, 32'h0);
        wr(5'h08, 32'hF);

        // Set beats same-cycle CLEAR
        irq_src[2] = 1'b0;
        repeat (3) cycle();
        irq_src[2] = 1'b1;
        cycle(); cycle();
        wr(5'h0C, 32'h4);
        rd(5'h00);
        checkEq("t4_set_wins", bus.reg_rdata & 32'h4, 32'h4);

`ifdef IRQ_TIMER_EN
        wr(5'h04, 32'h8000_0000);
        wr(5'h14, 32'd9);
        wr(5'h10, 32'd0);
        repeat (10) cycle();
        checkEq("t5_out_early", 32'(irq_out), 32'h0);
        cycle();
        checkEq("t5_out", 32'(irq_out), 32'h1);
        checkEq("t5_id", 32'(irq_id), 32'd31);
        rd(5'h10);
        checkEq("t5_cnt_wrap", bus.reg_rdata, 32'd1);
        wr(5'h14, 32'hFFFF_FFFF);
        wr(5'h0C, 32'h8000_0000);
`else
        wr(5'h10, 32'h1234);
        wr(5'h14, 32'h5);
        rd(5'h10);
        checkEq("t5_cnt_absent", bus.reg_rdata, 32'h0);
        rd(5'h14);
        checkEq("t5_cmp_absent", bus.reg_rdata, 32'h0);
`endif

        // Reset mid-interrupt with sources held high
        irq_src = '1;
        wr(5'h04, 32'hF);
        repeat (4) cycle();
        checkEq("t6_out_pre", 32'(irq_out), 32'h1);
        #2 rst = 1'b0;
        #1;
        checkEq("t6_rst_out", 32'(irq_out), 32'h0);
        checkEq("t6_rst_id", 32'(irq_id), 32'h0);
        checkEq("t6_rst_rdata", bus.reg_rdata, 32'h0);
        modelReset();
        repeat (2) cycle();
        rst = 1'b1;
        wr(5'h04, 32'hF);
        cycle();
        rd(5'h00);
        checkEq("t6_pend_r3", bus.reg_rdata, 32'h0);
        rd(5'h00);
        checkEq("t6_pend_r4", bus.reg_rdata, 32'hF);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < NUM_SRC; b++)
                if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
            stall         = ($urandom_range(0, 9) == 0);
            irq_ack       = ($urandom_range(0, 6) == 0);
            bus.reg_we    = ($urandom_range(0, 6) == 0);
            bus.reg_re    = ($urandom_range(0, 2) == 0);
            bus.reg_addr  = 5'($urandom_range(0, 31));
            bus.reg_wdata = $urandom;
            cycle();
        end
        bus.reg_we = 1'b0; bus.reg_re = 1'b0; irq_ack = 1'b0; stall = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
